// File: rtl/mem_bus_if.sv
// Bundles the fetch port, data port, memory-side and routed-return signals shared around mem_bus_arbiter.
interface mem_bus_if;
   logic [1:0]  proc2Imem_command;
   logic [63:0] proc2Imem_addr;
   logic [1:0]  proc2Dmem_command;
   logic [63:0] proc2Dmem_addr;
   logic [63:0] proc2Dmem_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  Imem2proc_response;
   logic [3:0]  Dmem2proc_response;
   logic [63:0] Imem2proc_data;
   logic [63:0] Dmem2proc_data;
   logic [3:0]  Imem2proc_tag;
   logic [3:0]  Dmem2proc_tag;
   logic        arb_idle;
   logic        arb_tag_error;

   modport slave (
      input  proc2Imem_command, proc2Imem_addr,
      input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output Imem2proc_response, Dmem2proc_response,
      output Imem2proc_data, Dmem2proc_data,
      output Imem2proc_tag, Dmem2proc_tag,
      output arb_idle, arb_tag_error
   );

   modport master (
      output proc2Imem_command, proc2Imem_addr,
      output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  Imem2proc_response, Dmem2proc_response,
      input  Imem2proc_data, Dmem2proc_data,
      input  Imem2proc_tag, Dmem2proc_tag,
      input  arb_idle, arb_tag_error
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch vs data onto one memory bus (data first, fetch after STARVE_LIMIT denials),
// zero-latency grant/response/return routing; losers are simply not answered and retry.
`ifndef SD
`define SD
`endif

module mem_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic       clock,
   input logic       reset,
   mem_bus_if.slave  bus
);
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

   logic [3:0]  r_starve_cnt;
   logic [15:0] r_valid;
   logic [15:0] r_owner;
   logic        r_tag_error;

   logic        w_i_req, w_d_req, w_grant_i, w_grant_d;
   logic        w_accept, w_install, w_ret_hit, w_ret_miss, w_ret_owner;
   logic [1:0]  w_win_cmd;
   logic [3:0]  w_starve_nxt;
   logic [15:0] w_valid_nxt, w_owner_nxt;

   assign w_i_req   = (bus.proc2Imem_command != BUS_NONE);
   assign w_d_req   = (bus.proc2Dmem_command != BUS_NONE);
   assign w_grant_i = w_i_req && (!w_d_req || (r_starve_cnt == LIMIT));
   assign w_grant_d = w_d_req && !w_grant_i;
   assign w_win_cmd = w_grant_d ? bus.proc2Dmem_command :
                      w_grant_i ? bus.proc2Imem_command : BUS_NONE;
   assign w_accept  = (w_grant_i || w_grant_d) && (bus.mem2proc_response != 4'd0);
   assign w_install = w_accept && (w_win_cmd == BUS_LOAD);

   assign bus.proc2mem_command   = w_win_cmd;
   assign bus.proc2mem_addr      = w_grant_d ? bus.proc2Dmem_addr :
                                   w_grant_i ? bus.proc2Imem_addr : 64'd0;
   assign bus.proc2mem_data      = w_grant_d ? bus.proc2Dmem_data : 64'd0;
   assign bus.Imem2proc_response = w_grant_i ? bus.mem2proc_response : 4'd0;
   assign bus.Dmem2proc_response = w_grant_d ? bus.mem2proc_response : 4'd0;

   // Returns are routed against the registered table, so a same-tag install this cycle
   // cannot steal the data from the entry it replaces.
   always_comb begin
      w_valid_nxt = r_valid;
      w_owner_nxt = r_owner;
      w_ret_hit   = 1'b0;
      w_ret_miss  = 1'b0;
      w_ret_owner = r_owner[bus.mem2proc_tag];
      if (bus.mem2proc_tag != 4'd0) begin
         if (r_valid[bus.mem2proc_tag]) begin
            w_ret_hit                     = 1'b1;
            w_valid_nxt[bus.mem2proc_tag] = 1'b0;
         end else begin
            w_ret_miss = 1'b1;
         end
      end
      if (w_install) begin
         w_valid_nxt[bus.mem2proc_response] = 1'b1;
         w_owner_nxt[bus.mem2proc_response] = w_grant_d;
      end
      w_valid_nxt[0] = 1'b0;
      w_owner_nxt[0] = 1'b0;
   end

   assign bus.Imem2proc_tag  = (w_ret_hit && !w_ret_owner) ? bus.mem2proc_tag  : 4'd0;
   assign bus.Imem2proc_data = (w_ret_hit && !w_ret_owner) ? bus.mem2proc_data : 64'd0;
   assign bus.Dmem2proc_tag  = (w_ret_hit &&  w_ret_owner) ? bus.mem2proc_tag  : 4'd0;
   assign bus.Dmem2proc_data = (w_ret_hit &&  w_ret_owner) ? bus.mem2proc_data : 64'd0;
   assign bus.arb_idle       = ~|r_valid;
   assign bus.arb_tag_error  = r_tag_error;

   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!w_i_req || (w_grant_i && w_accept))
         w_starve_nxt = 4'd0;
      else if (r_starve_cnt < LIMIT)
         w_starve_nxt = r_starve_cnt + 4'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_starve_cnt <= `SD 4'd0;
         r_valid      <= `SD 16'd0;
         r_owner      <= `SD 16'd0;
         r_tag_error  <= `SD 1'b0;
      end else begin
         r_starve_cnt <= `SD w_starve_nxt;
         r_valid      <= `SD w_valid_nxt;
         r_owner      <= `SD w_owner_nxt;
         r_tag_error  <= `SD r_tag_error | w_ret_miss;
      end
   end
endmodule
